// File: rtl/stream_job_sequencer.sv
// stream_job_sequencer: copies a job of cache lines by issuing credit-limited reads
// and data-driven writes, then waits for every write completion before pulsing done.
module stream_job_sequencer #(
    parameter int CL_ADDR_W  = 42,
    parameter int LEN_W      = 32,
    parameter int RD_CREDITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len_lines,
    input  logic [CL_ADDR_W-1:0] src_cl_addr,
    input  logic [CL_ADDR_W-1:0] dst_cl_addr,
    input  logic                 rd_almfull,
    output logic                 rd_req_valid,
    output logic [CL_ADDR_W-1:0] rd_req_addr,
    input  logic                 rd_rsp_valid,
    input  logic                 rd_credit_ret,
    input  logic                 wr_data_avail,
    input  logic                 wr_almfull,
    output logic                 wr_req_valid,
    output logic [CL_ADDR_W-1:0] wr_req_addr,
    input  logic                 wr_ack_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CR_W = $clog2(RD_CREDITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               r_state, w_state_nx;
    logic [LEN_W-1:0]     r_len, r_rd_issued, r_rd_rcvd, r_wr_issued, r_wr_acked;
    logic [CL_ADDR_W-1:0] r_src, r_dst, r_rd_addr, r_wr_addr;
    logic [CR_W-1:0]      r_credits;
    logic                 r_rd_valid, r_wr_valid, r_err;
    logic                 w_launch, w_rd_go, w_wr_go, w_rsp_bad, w_ack_bad, w_ret_bad;

    assign w_launch  = r_state == IDLE && start;
    assign w_rd_go   = r_state == RUN && r_rd_issued < r_len && r_credits != '0 && !rd_almfull;
    assign w_wr_go   = r_state == RUN && wr_data_avail && r_wr_issued < r_len && !wr_almfull;
    // Protocol violations: more responses/acks than requests, or credits beyond capacity.
    assign w_rsp_bad = rd_rsp_valid && r_rd_rcvd == r_rd_issued;
    assign w_ack_bad = wr_ack_valid && r_wr_acked == r_wr_issued;
    assign w_ret_bad = rd_credit_ret && r_credits == CR_W'(RD_CREDITS);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = (len_lines == '0) ? DONE : RUN;
            RUN:     if (w_wr_go && r_wr_issued + LEN_W'(1) == r_len) w_state_nx = DRAIN;
            DRAIN:   if (wr_ack_valid && r_wr_acked + LEN_W'(1) == r_len) w_state_nx = DONE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_rd_issued <= '0;
            r_rd_rcvd   <= '0;
            r_wr_issued <= '0;
            r_wr_acked  <= '0;
            r_credits   <= CR_W'(RD_CREDITS);
            r_rd_valid  <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rd_valid <= w_rd_go;
            r_wr_valid <= w_wr_go;
            if (w_rd_go) r_rd_addr <= r_src + CL_ADDR_W'(r_rd_issued);
            if (w_wr_go) r_wr_addr <= r_dst + CL_ADDR_W'(r_wr_issued);
            r_credits <= r_credits - CR_W'(w_rd_go) + CR_W'(rd_credit_ret && !w_ret_bad);
            if (w_launch) begin
                r_len       <= len_lines;
                r_src       <= src_cl_addr;
                r_dst       <= dst_cl_addr;
                r_rd_issued <= '0;
                r_rd_rcvd   <= '0;
                r_wr_issued <= '0;
                r_wr_acked  <= '0;
                r_err       <= 1'b0;
            end else begin
                r_rd_issued <= r_rd_issued + LEN_W'(w_rd_go);
                r_wr_issued <= r_wr_issued + LEN_W'(w_wr_go);
                r_rd_rcvd   <= r_rd_rcvd + LEN_W'(rd_rsp_valid && !w_rsp_bad);
                r_wr_acked  <= r_wr_acked + LEN_W'(wr_ack_valid && !w_ack_bad);
                if (w_rsp_bad || w_ack_bad || w_ret_bad) r_err <= 1'b1;
            end
        end
    end

    assign rd_req_valid = r_rd_valid;
    assign rd_req_addr  = r_rd_addr;
    assign wr_req_valid = r_wr_valid;
    assign wr_req_addr  = r_wr_addr;
    assign busy         = r_state != IDLE;
    assign done         = r_state == DONE;
    assign err          = r_err;
endmodule
